pd_debug_capture_seq: RTL and testbench



---
 rtl/pd_dbg_seq_pkg.sv | 45 ++++
 rtl/pd_dbg_seq_timer.sv | 38 +++
 rtl/pd_debug_capture_seq.sv | 204 ++++++++++++++++++++
 tb/tb_pd_debug_capture_seq.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pd_dbg_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pd_dbg_seq_pkg
// Description : Shared types and constants for the PD debug capture sequencer:
//               capture mode, FSM state encoding and enable-register values.
// Revision    : 1.0 - initial release
// ============================================================================
package pd_dbg_seq_pkg;

    // Capture mode as seen by the FSM (raw code 3 folds onto FIRST)
    typedef enum logic [1:0] {
        MODE_FIRST   = 2'd0,
        MODE_TRIGGER = 2'd1,
        MODE_LAST    = 2'd2
    } mode_t;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CLEAR   = 3'd1,
        ST_WAIT    = 3'd2,
        ST_FREEZE  = 3'd3,
        ST_SETTLE  = 3'd4,
        ST_PRESENT = 3'd5,
        ST_DONE    = 3'd6
    } state_t;

    // Capture-block enable register {last_en, trig_en, capture_en, en}
    localparam logic [3:0] EN_OFF   = 4'b0000;
    localparam logic [3:0] EN_CLEAR = 4'b0001;
    localparam logic [3:0] EN_FIRST = 4'b0011;
    localparam logic [3:0] EN_TRIG  = 4'b0111;
    localparam logic [3:0] EN_LAST  = 4'b1011;
    localparam logic [3:0] EN_HOLD  = 4'b0001;

    // Map the raw configuration code onto a capture mode
    function automatic mode_t decode_mode(input logic [1:0] raw);
        case (raw)
            2'd1:    return MODE_TRIGGER;
            2'd2:    return MODE_LAST;
            default: return MODE_FIRST;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/pd_dbg_seq_timer.sv
`default_nettype none
// ============================================================================
// Module      : pd_dbg_seq_timer
// Description : Loadable down-counter. Loading N makes o_expired rise on the
//               N-th decrement cycle after the load; loading 0 never expires.
// Revision    : 1.0 - initial release
// ============================================================================
module pd_dbg_seq_timer #(
    parameter int TO_W = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_load,
    input  logic [TO_W-1:0] i_load_val,
    input  logic            i_dec,
    output logic            o_expired
);

    logic [TO_W-1:0] r_cnt;
    logic            r_active;

    // Counter holds (remaining cycles - 1); a zero load leaves it inactive
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt    <= '0;
            r_active <= 1'b0;
        end else if (i_load) begin
            r_cnt    <= i_load_val - TO_W'(1);
            r_active <= (i_load_val != '0);
        end else if (i_dec && (r_cnt != '0)) begin
            r_cnt    <= r_cnt - TO_W'(1);
        end
    end

    assign o_expired = r_active && (r_cnt == '0);

endmodule
`default_nettype wire

// File: rtl/pd_debug_capture_seq.sv
`default_nettype none
// ============================================================================
// Module      : pd_debug_capture_seq
// Description : Arms the PD capture block, waits for a capture match or a
//               timeout, freezes the capture and streams every 32b word of
//               the captured PD out on a valid/ready port.
// Revision    : 1.0 - initial release
// ============================================================================
module pd_debug_capture_seq
    import pd_dbg_seq_pkg::*;
#(
    parameter  int PD_WIDTH    = 100,
    parameter  int MUX_LATENCY = 2,
    parameter  int TO_W        = 16,
    localparam int NUM_WORDS   = (PD_WIDTH + 31) / 32,
    localparam int SEL_W       = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic             abort_i,
    input  logic [1:0]       cfg_mode_i,
    input  logic [TO_W-1:0]  cfg_timeout_i,
    input  logic             capture_match_i,
    input  logic [31:0]      pd_word_i,
    output logic [3:0]       en_reg_o,
    output logic [SEL_W-1:0] word_sel_o,
    output logic             rd_valid_o,
    output logic [31:0]      rd_data_o,
    output logic             rd_last_o,
    input  logic             rd_ready_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             timeout_o
);

    localparam logic [SEL_W-1:0] c_last_sel = SEL_W'(NUM_WORDS - 1);

    state_t          r_state, w_state_next;
    mode_t           r_mode;
    logic [TO_W-1:0] r_cfg_timeout;
    logic            r_seen;
    logic [SEL_W-1:0] r_word_sel;
    logic [31:0]     r_rd_data;
    logic            r_timeout;

    logic            w_start_acc, w_set_seen, w_set_timeout;
    logic            w_sel_clr, w_sel_inc, w_data_load;
    logic            w_tmr_load, w_tmr_dec, w_tmr_expired;
    logic [TO_W-1:0] w_tmr_val;

    // One timer serves both the capture wait limit and the word-select settle delay
    pd_dbg_seq_timer #(.TO_W(TO_W)) u_timer (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_tmr_load),
        .i_load_val (w_tmr_val),
        .i_dec      (w_tmr_dec),
        .o_expired  (w_tmr_expired)
    );

    // Next-state, datapath strobes and state-decoded outputs
    always_comb begin
        w_state_next  = r_state;
        w_start_acc   = 1'b0;
        w_set_seen    = 1'b0;
        w_set_timeout = 1'b0;
        w_sel_clr     = 1'b0;
        w_sel_inc     = 1'b0;
        w_data_load   = 1'b0;
        w_tmr_load    = 1'b0;
        w_tmr_dec     = 1'b0;
        w_tmr_val     = '0;
        en_reg_o      = EN_OFF;
        rd_valid_o    = 1'b0;
        rd_last_o     = 1'b0;
        done_o        = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (start_i) begin
                    w_start_acc  = 1'b1;
                    w_state_next = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                // capture_en low for a cycle clears the block's sticky captured flag
                en_reg_o     = EN_CLEAR;
                w_tmr_load   = 1'b1;
                w_tmr_val    = r_cfg_timeout;
                w_state_next = ST_WAIT;
            end
            ST_WAIT: begin
                case (r_mode)
                    MODE_TRIGGER: en_reg_o = EN_TRIG;
                    MODE_LAST:    en_reg_o = EN_LAST;
                    default:      en_reg_o = EN_FIRST;
                endcase
                w_tmr_dec = 1'b1;
                if (capture_match_i) begin
                    // A match beats a coincident timeout; in LAST it counts as seen
                    if (r_mode == MODE_LAST) begin
                        w_set_seen = 1'b1;
                        if (w_tmr_expired) w_state_next = ST_FREEZE;
                    end else begin
                        w_state_next = ST_FREEZE;
                    end
                end else if (w_tmr_expired) begin
                    if ((r_mode == MODE_LAST) && r_seen) begin
                        w_state_next = ST_FREEZE;
                    end else begin
                        w_set_timeout = 1'b1;
                        w_state_next  = ST_IDLE;
                    end
                end
            end
            ST_FREEZE: begin
                en_reg_o     = EN_HOLD;
                w_sel_clr    = 1'b1;
                w_tmr_load   = 1'b1;
                w_tmr_val    = TO_W'(MUX_LATENCY);
                w_state_next = ST_SETTLE;
            end
            ST_SETTLE: begin
                en_reg_o  = EN_HOLD;
                w_tmr_dec = 1'b1;
                if (w_tmr_expired) begin
                    w_data_load  = 1'b1;
                    w_state_next = ST_PRESENT;
                end
            end
            ST_PRESENT: begin
                en_reg_o   = EN_HOLD;
                rd_valid_o = 1'b1;
                rd_last_o  = (r_word_sel == c_last_sel);
                if (rd_ready_i) begin
                    if (r_word_sel == c_last_sel) begin
                        w_state_next = ST_DONE;
                    end else begin
                        w_sel_inc    = 1'b1;
                        w_tmr_load   = 1'b1;
                        w_tmr_val    = TO_W'(MUX_LATENCY);
                        w_state_next = ST_SETTLE;
                    end
                end
            end
            ST_DONE: begin
                en_reg_o     = EN_HOLD;
                done_o       = 1'b1;
                w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase

        // Abort overrides everything, including a simultaneous start
        if (abort_i) begin
            w_state_next  = ST_IDLE;
            w_start_acc   = 1'b0;
            w_set_seen    = 1'b0;
            w_set_timeout = 1'b0;
            w_sel_clr     = 1'b0;
            w_sel_inc     = 1'b0;
            w_data_load   = 1'b0;
            w_tmr_load    = 1'b0;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_next;
    end

    // Configuration latch, match/timeout flags, word select and readout data
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mode        <= MODE_FIRST;
            r_cfg_timeout <= '0;
            r_seen        <= 1'b0;
            r_timeout     <= 1'b0;
            r_word_sel    <= '0;
            r_rd_data     <= '0;
        end else begin
            if (w_start_acc) begin
                r_mode        <= decode_mode(cfg_mode_i);
                r_cfg_timeout <= cfg_timeout_i;
                r_seen        <= 1'b0;
                r_timeout     <= 1'b0;
            end
            if (w_set_seen)    r_seen    <= 1'b1;
            if (w_set_timeout) r_timeout <= 1'b1;
            if (w_sel_clr)      r_word_sel <= '0;
            else if (w_sel_inc) r_word_sel <= r_word_sel + SEL_W'(1);
            if (w_data_load)   r_rd_data <= pd_word_i;
        end
    end

    assign word_sel_o = r_word_sel;
    assign rd_data_o  = r_rd_data;
    assign busy_o     = (r_state != ST_IDLE);
    assign timeout_o  = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_pd_debug_capture_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_pd_debug_capture_seq
// Description : Self-checking bench for pd_debug_capture_seq with a simple
//               capture-block model and a rule-level reference of which PD
//               gets read out, when, and whether a timeout occurs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pd_debug_capture_seq;

    localparam int PD_WIDTH    = 100;
    localparam int MUX_LATENCY = 2;
    localparam int TO_W        = 16;
    localparam int NUM_WORDS   = 4;
    localparam int SEL_W       = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic              start_i, abort_i;
    logic [1:0]        cfg_mode_i;
    logic [TO_W-1:0]   cfg_timeout_i;
    logic              capture_match_i;
    logic [31:0]       pd_word_i = '0;
    logic [3:0]        en_reg_o;
    logic [SEL_W-1:0]  word_sel_o;
    logic              rd_valid_o;
    logic [31:0]       rd_data_o;
    logic              rd_last_o;
    logic              rd_ready_i;
    logic              busy_o, done_o, timeout_o;

    int checks   = 0;
    int failures = 0;

    int           match_q[$];
    logic [127:0] pd_q[$];
    logic [127:0] live_pd = '0;
    logic [127:0] cap_pd  = '0;
    logic         cap_flag = 1'b0;

    always #5 clk = ~clk;

    pd_debug_capture_seq #(
        .PD_WIDTH    (PD_WIDTH),
        .MUX_LATENCY (MUX_LATENCY),
        .TO_W        (TO_W)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .start_i         (start_i),
        .abort_i         (abort_i),
        .cfg_mode_i      (cfg_mode_i),
        .cfg_timeout_i   (cfg_timeout_i),
        .capture_match_i (capture_match_i),
        .pd_word_i       (pd_word_i),
        .en_reg_o        (en_reg_o),
        .word_sel_o      (word_sel_o),
        .rd_valid_o      (rd_valid_o),
        .rd_data_o       (rd_data_o),
        .rd_last_o       (rd_last_o),
        .rd_ready_i      (rd_ready_i),
        .busy_o          (busy_o),
        .done_o          (done_o),
        .timeout_o       (timeout_o)
    );

    // Capture block: sticky first capture, overwrite when last_en, cleared by capture_en=0
    always @(posedge clk) begin
        if (!en_reg_o[1]) begin
            cap_flag <= 1'b0;
        end else if (capture_match_i && (en_reg_o[3] || !cap_flag)) begin
            cap_pd   <= live_pd;
            cap_flag <= 1'b1;
        end
        pd_word_i <= cap_pd[word_sel_o*32 +: 32];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", name, obs, exp);
        end
    endtask

    function automatic logic [127:0] rand_pd();
        logic [3:0] top;
        top = 4'($urandom);
        return {28'h0, top, $urandom, $urandom, $urandom};
    endfunction

    // One complete sequence; expectations come from the mode/timeout/match rules
    task automatic run_seq(input string tag, input int mode, input int tmo,
                           input int stall_word, input int stall_len,
                           input int abort_word, input bit busy_start);
        int           end_w, sel_idx, lat;
        bit           exp_read;
        logic [127:0] exp_pd;
        logic [3:0]   exp_en;
        logic [31:0]  held;

        pd_q.delete();
        foreach (match_q[i]) pd_q.push_back(rand_pd());
        exp_read = 1'b0;
        sel_idx  = -1;
        exp_pd   = '0;
        if (mode == 2) begin
            end_w = tmo - 1;
            foreach (match_q[i]) if (match_q[i] <= end_w) begin sel_idx = i; exp_read = 1'b1; end
        end else if (match_q.size() > 0 && (tmo == 0 || match_q[0] <= tmo - 1)) begin
            end_w    = match_q[0];
            sel_idx  = 0;
            exp_read = 1'b1;
        end else begin
            end_w = tmo - 1;
        end
        if (exp_read) exp_pd = pd_q[sel_idx];
        exp_en = (mode == 1) ? 4'b0111 : (mode == 2) ? 4'b1011 : 4'b0011;

        cfg_mode_i    = 2'(mode);
        cfg_timeout_i = TO_W'(tmo);
        start_i       = 1'b1;
        tick();
        start_i = 1'b0;
        check({tag, "/clear_en"}, 64'(en_reg_o), 64'(4'b0001));
        check({tag, "/clear_busy"}, 64'(busy_o), 64'd1);
        check({tag, "/clear_timeout"}, 64'(timeout_o), 64'd0);
        tick();

        for (int w = 0; w <= end_w; w++) begin
            check({tag, "/wait_en"}, 64'(en_reg_o), 64'(exp_en));
            capture_match_i = 1'b0;
            foreach (match_q[i]) if (match_q[i] == w) begin capture_match_i = 1'b1; live_pd = pd_q[i]; end
            if (busy_start && w == 2) begin start_i = 1'b1; cfg_mode_i = 2'd2; cfg_timeout_i = 16'd3; end
            tick();
            capture_match_i = 1'b0;
            start_i         = 1'b0;
        end

        if (!exp_read) begin
            check({tag, "/to_flag"}, 64'(timeout_o), 64'd1);
            check({tag, "/to_busy"}, 64'(busy_o), 64'd0);
            check({tag, "/to_en"}, 64'(en_reg_o), 64'd0);
            for (int s = 0; s < 4; s++) begin
                check({tag, "/to_novalid"}, 64'({rd_valid_o, done_o}), 64'd0);
                tick();
            end
            return;
        end

        check({tag, "/freeze_en"}, 64'(en_reg_o), 64'(4'b0001));
        lat = 1;
        while (!rd_valid_o && lat < 50) begin tick(); lat++; end
        check({tag, "/first_latency"}, 64'(lat), 64'(MUX_LATENCY + 2));

        for (int k = 0; k < NUM_WORDS; k++) begin
            check({tag, "/valid"}, 64'(rd_valid_o), 64'd1);
            check({tag, "/data"}, 64'(rd_data_o), 64'(exp_pd[32*k +: 32]));
            check({tag, "/last"}, 64'(rd_last_o), 64'(k == NUM_WORDS - 1));
            check({tag, "/sel"}, 64'(word_sel_o), 64'(k));
            check({tag, "/hold_en"}, 64'(en_reg_o), 64'(4'b0001));
            if (k == abort_word) begin
                abort_i = 1'b1;
                tick();
                abort_i = 1'b0;
                check({tag, "/abort_state"}, 64'({busy_o, rd_valid_o, done_o}), 64'd0);
                check({tag, "/abort_en"}, 64'(en_reg_o), 64'd0);
                tick();
                check({tag, "/abort_nodone"}, 64'(done_o), 64'd0);
                return;
            end
            if (k == stall_word) begin
                held = rd_data_o;
                for (int s = 0; s < stall_len; s++) begin
                    tick();
                    check({tag, "/stall"}, 64'({rd_valid_o, word_sel_o, rd_data_o}),
                          64'({1'b1, SEL_W'(k), held}));
                end
            end
            rd_ready_i = 1'b1;
            tick();
            rd_ready_i = 1'b0;
            if (k == NUM_WORDS - 1) begin
                check({tag, "/done"}, 64'({done_o, rd_valid_o}), 64'b10);
                tick();
                check({tag, "/after_done"}, 64'({done_o, busy_o, en_reg_o}), 64'd0);
            end else begin
                check({tag, "/gap_nodone"}, 64'(done_o), 64'd0);
                lat = 1;
                while (!rd_valid_o && lat < 50) begin tick(); lat++; end
                check({tag, "/word_gap"}, 64'(lat), 64'(MUX_LATENCY + 1));
            end
        end
        check({tag, "/no_timeout"}, 64'(timeout_o), 64'd0);
    endtask

    initial begin
        int mode, tmo, n, pos;

        rst = 1'b1; start_i = 1'b0; abort_i = 1'b0; cfg_mode_i = '0; cfg_timeout_i = '0;
        capture_match_i = 1'b0; rd_ready_i = 1'b0;
        repeat (3) tick();
        check("reset_outputs", 64'({en_reg_o, word_sel_o, rd_valid_o, rd_last_o, busy_o, done_o, timeout_o}), 64'd0);
        check("reset_data", 64'(rd_data_o), 64'd0);
        rst = 1'b0;
        tick();

        match_q = '{10};       run_seq("first",      0, 0,  1, 5, -1, 1'b0);
        match_q = '{7};        run_seq("trigger",    1, 0, -1, 0, -1, 1'b1);
        match_q.delete();      run_seq("timeout",    0, 20, -1, 0, -1, 1'b0);
        match_q = '{5, 9, 14}; run_seq("last",       2, 30, 2, 2, -1, 1'b0);
        match_q.delete();      run_seq("last_none",  2, 30, -1, 0, -1, 1'b0);

        // Abort and start together: abort wins and the sticky timeout survives
        abort_i = 1'b1; start_i = 1'b1;
        tick();
        abort_i = 1'b0; start_i = 1'b0;
        check("abort_start_busy", 64'(busy_o), 64'd0);
        check("abort_keeps_timeout", 64'(timeout_o), 64'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_clears_timeout", 64'(timeout_o), 64'd0);

        match_q = '{6};        run_seq("abort",      0, 0,  -1, 0, 2, 1'b0);
        match_q = '{4};        run_seq("post_abort", 3, 200, 0, 1, -1, 1'b0);
        match_q = '{11};       run_seq("tie",        0, 12, -1, 0, -1, 1'b0);

        // Reset in the middle of WAIT returns everything to reset values
        cfg_mode_i = 2'd1; cfg_timeout_i = '0; start_i = 1'b1;
        tick();
        start_i = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_outputs", 64'({en_reg_o, word_sel_o, rd_valid_o, busy_o, done_o, timeout_o}), 64'd0);
        tick();

        for (int r = 0; r < 8; r++) begin
            mode = int'($urandom_range(0, 3));
            match_q.delete();
            if (mode == 2) begin
                tmo = int'($urandom_range(5, 40));
                n   = int'($urandom_range(0, 3));
                pos = int'($urandom_range(0, 4));
                for (int i = 0; i < n; i++) begin
                    match_q.push_back(pos);
                    pos += int'($urandom_range(1, 8));
                end
            end else begin
                tmo = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(5, 40));
                if (tmo == 0 || $urandom_range(0, 2) != 0) match_q.push_back(int'($urandom_range(0, 45)));
            end
            run_seq("random", mode, tmo, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), -1, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
